// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and character-cell geometry
// used by the timing generator and the character-display path.
package vga_pkg;

   localparam int COORD_W = 10;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int CHAR_W = 8;
   localparam int CHAR_H = 16;

   function automatic logic [COORD_W-1:0] char_col(input logic [COORD_W-1:0] px);
      return px / COORD_W'(CHAR_W);
   endfunction

   function automatic logic [COORD_W-1:0] char_row(input logic [COORD_W-1:0] ln);
      return ln / COORD_W'(CHAR_H);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one display axis; count registers on advance, flags are
// combinational and describe the value being loaded (count_next).
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               advance,
   output logic [COORD_W-1:0] count,
   output logic               wrap,
   output logic               visible_next,
   output logic               sync_next
);

   localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
   localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] VIS_END = COORD_W'(VISIBLE);
   localparam logic [COORD_W-1:0] SYNC_LO = COORD_W'(VISIBLE + FRONT);
   localparam logic [COORD_W-1:0] SYNC_HI = COORD_W'(VISIBLE + FRONT + SYNC);

   logic [COORD_W-1:0] count_next;

   always_comb begin
      wrap       = advance && (count == LAST);
      count_next = count;
      if (wrap)
         count_next = '0;
      else if (advance)
         count_next = count + 1'b1;
   end

   assign visible_next = (count_next < VIS_END);
   assign sync_next    = (count_next >= SYNC_LO) && (count_next < SYNC_HI);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blank/coordinate generator on clk with a pix_en strobe; sync and blank
// lag x/y by SYNC_DELAY ticks. Define VGA_FRAME_COUNTER_EN to add frame_count.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE  = H_VISIBLE_DEF,
   parameter int H_FRONT    = H_FRONT_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BACK     = H_BACK_DEF,
   parameter int V_VISIBLE  = V_VISIBLE_DEF,
   parameter int V_FRONT    = V_FRONT_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BACK     = V_BACK_DEF,
   parameter int SYNC_POL   = 0,
   parameter int SYNC_DELAY = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pix_en,
   output logic                hsync,
   output logic                vsync,
   output logic                blank,
   output logic [COORD_W-1:0]  x,
   output logic [COORD_W-1:0]  y,
   output logic                line_start,
   output logic                frame_start
`ifdef VGA_FRAME_COUNTER_EN
   ,
   output logic [7:0]          frame_count
`endif
);

   localparam logic ACT = (SYNC_POL != 0);

   logic h_wrap, h_vis, h_sync;
   logic v_wrap, v_vis, v_sync;
   logic [SYNC_DELAY:0] hs_pipe, vs_pipe, bl_pipe;

   vga_axis_counter #(
      .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
   ) u_h_cnt (
      .clk(clk), .reset(reset), .advance(pix_en),
      .count(x), .wrap(h_wrap), .visible_next(h_vis), .sync_next(h_sync)
   );

   vga_axis_counter #(
      .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
   ) u_v_cnt (
      .clk(clk), .reset(reset), .advance(h_wrap),
      .count(y), .wrap(v_wrap), .visible_next(v_vis), .sync_next(v_sync)
   );

   // Stage 0 loads alongside x/y, so SYNC_DELAY=0 keeps sync aligned with the counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_pipe     <= {(SYNC_DELAY+1){~ACT}};
         vs_pipe     <= {(SYNC_DELAY+1){~ACT}};
         bl_pipe     <= '1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= h_wrap;
         frame_start <= h_wrap & v_wrap;
         if (pix_en) begin
            hs_pipe[0] <= h_sync ? ACT : ~ACT;
            vs_pipe[0] <= v_sync ? ACT : ~ACT;
            bl_pipe[0] <= ~(h_vis & v_vis);
            for (int i = 1; i <= SYNC_DELAY; i++) begin
               hs_pipe[i] <= hs_pipe[i-1];
               vs_pipe[i] <= vs_pipe[i-1];
               bl_pipe[i] <= bl_pipe[i-1];
            end
         end
      end
   end

   assign hsync = hs_pipe[SYNC_DELAY];
   assign vsync = vs_pipe[SYNC_DELAY];
   assign blank = bl_pipe[SYNC_DELAY];

`ifdef VGA_FRAME_COUNTER_EN
   always_ff @(posedge clk) begin
      if (reset)
         frame_count <= 8'd0;
      else if (h_wrap & v_wrap)
         frame_count <= frame_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance and a shortened-timing
// instance (SYNC_DELAY=2, active-high sync) checked against a tick-count model.
module tb_vga_timing_gen;

   // shortened timing for the second instance
   localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
   localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;
   localparam int HT1 = S_HV + S_HF + S_HS + S_HB;
   localparam int VT1 = S_VV + S_VF + S_VS + S_VB;
   localparam int FR1 = HT1 * VT1;
   localparam int D0 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, pe0, rst1, pe1;
   logic hsync0, vsync0, blank0, ls0, fs0;
   logic hsync1, vsync1, blank1, ls1, fs1;
   logic [9:0] x0, y0, x1, y1;
`ifdef VGA_FRAME_COUNTER_EN
   logic [7:0] fc0, fc1;
`endif

   vga_timing_gen dut0 (
      .clk(clk), .reset(rst0), .pix_en(pe0),
      .hsync(hsync0), .vsync(vsync0), .blank(blank0), .x(x0), .y(y0),
      .line_start(ls0), .frame_start(fs0)
`ifdef VGA_FRAME_COUNTER_EN
      , .frame_count(fc0)
`endif
   );

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
      .SYNC_POL(1), .SYNC_DELAY(2)
   ) dut1 (
      .clk(clk), .reset(rst1), .pix_en(pe1),
      .hsync(hsync1), .vsync(vsync1), .blank(blank1), .x(x1), .y(y1),
      .line_start(ls1), .frame_start(fs1)
`ifdef VGA_FRAME_COUNTER_EN
      , .frame_count(fc1)
`endif
   );

   logic [24:0] obs0, obs1;
   assign obs0 = {x0, y0, hsync0, vsync0, blank0, ls0, fs0};
   assign obs1 = {x1, y1, hsync1, vsync1, blank1, ls1, fs1};

   int  vectors = 0, miscompares = 0;
   int  n0 = 0, n1 = 0;   // pixel ticks since the last reset
   bit  t0 = 0, t1 = 0;   // a tick happened on the latest edge

   // Outputs after n ticks: position is n mod frame, sync/blank describe position n-dly,
   // and anything reaching back to or before the reset point reads as inactive/blank.
   function automatic logic [24:0] model_out(input int n, input bit ticked,
         input int hv, input int hf, input int hsw, input int hb,
         input int vv, input int vf, input int vsw, input int vb,
         input int dly, input bit pol);
      int ht, vt, fr, px, py, m, qx, qy;
      logic hs, vs, bl, ls, fs;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      fr = ht * vt;
      px = (n % fr) % ht;
      py = (n % fr) / ht;
      m  = n - dly;
      hs = !pol; vs = !pol; bl = 1'b1;
      if (m > 0) begin
         qx = (m % fr) % ht;
         qy = (m % fr) / ht;
         bl = (qx >= hv) || (qy >= vv);
         if (qx >= hv + hf && qx < hv + hf + hsw) hs = pol;
         if (qy >= vv + vf && qy < vv + vf + vsw) vs = pol;
      end
      ls = ticked && (n > 0) && (px == 0);
      fs = ls && (py == 0);
      return {px[9:0], py[9:0], hs, vs, bl, ls, fs};
   endfunction

   function automatic logic [24:0] exp0();
      return model_out(n0, t0, 640, 16, 96, 48, 480, 10, 2, 33, D0, 1'b0);
   endfunction

   function automatic logic [24:0] exp1();
      return model_out(n1, t1, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 2, 1'b1);
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
      if (rst0) begin n0 = 0; t0 = 0; end
      else if (pe0) begin n0++; t0 = 1; end
      else t0 = 0;
      if (rst1) begin n1 = 0; t1 = 0; end
      else if (pe1) begin n1++; t1 = 1; end
      else t1 = 0;
   endtask

   task automatic test_reset();
      rst0 = 1; rst1 = 1; pe0 = 1; pe1 = 1;
      repeat (3) begin
         cycle();
         vectors++;
         if (obs0 !== 25'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0})) begin
            miscompares++;
            $display("FAIL reset0: got %h expected %h", obs0, {10'd0, 10'd0, 5'b11100});
         end
         vectors++;
         if (obs1 !== exp1()) begin
            miscompares++;
            $display("FAIL reset1: got %h expected %h", obs1, exp1());
         end
`ifdef VGA_FRAME_COUNTER_EN
         vectors++;
         if (fc0 !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_fc: got %0d expected 0", fc0);
         end
`endif
      end
      rst0 = 0; rst1 = 0; pe1 = 0;
      for (int c = 0; c < 16; c++) begin
         pe0 = (c % 4 == 0);
         cycle();
         vectors++;
         if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL release: got %h expected %h at n=%0d", obs0, exp0(), n0);
         end
      end
      pe0 = 0;
      vectors++;
      if (x0 !== 10'd4 || y0 !== 10'd0) begin
         miscompares++;
         $display("FAIL four_strobes: got x=%0d y=%0d expected x=4 y=0", x0, y0);
      end
   endtask

   task automatic test_line();
      int hs_low = 0, hs_first = -1, bl_rise = -1;
      bit prev_bl = 1;
      int ls_n[$];
      rst0 = 1; pe0 = 0; cycle(); rst0 = 0;
      for (int c = 0; c < 20000 && n0 < 1610; c++) begin
         pe0 = (c % 4 == 3) && ($urandom_range(0, 7) != 0);
         cycle();
         vectors++;
         if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL line0: got %h expected %h at n=%0d", obs0, exp0(), n0);
         end
         vectors++;
         if (obs1 !== exp1()) begin
            miscompares++;
            $display("FAIL frozen1: got %h expected %h", obs1, exp1());
         end
         if (t0) begin
            if (n0 <= 800 && hsync0 == 1'b0) begin
               hs_low++;
               if (hs_first < 0) hs_first = x0;
            end
            if (blank0 && !prev_bl && bl_rise < 0) bl_rise = x0;
            prev_bl = blank0;
            if (ls0) ls_n.push_back(n0);
         end
      end
      pe0 = 0;
      vectors++;
      if (n0 < 1610) begin
         miscompares++;
         $display("FAIL line_timeout: got %0d ticks expected 1610", n0);
      end
      vectors++;
      if (hs_low != 96) begin
         miscompares++;
         $display("FAIL hsync_width: got %0d expected 96", hs_low);
      end
      vectors++;
      if (hs_first != 656 + D0) begin
         miscompares++;
         $display("FAIL hsync_start: got x=%0d expected x=%0d", hs_first, 656 + D0);
      end
      vectors++;
      if (bl_rise != 640 + D0) begin
         miscompares++;
         $display("FAIL blank_rise: got x=%0d expected x=%0d", bl_rise, 640 + D0);
      end
      vectors++;
      if (ls_n.size() != 2 || ls_n[1] - ls_n[0] != 800) begin
         miscompares++;
         $display("FAIL line_period: got %0d pulses expected 2 pulses 800 apart", ls_n.size());
      end
   endtask

   task automatic test_mid_reset();
      rst0 = 1; pe0 = 1; cycle(); rst0 = 0;
      repeat (300) begin
         cycle();
         vectors++;
         if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL clkrate0: got %h expected %h at n=%0d", obs0, exp0(), n0);
         end
      end
      vectors++;
      if (x0 !== 10'd300) begin
         miscompares++;
         $display("FAIL pre_reset_x: got %0d expected 300", x0);
      end
      rst0 = 1;
      cycle();
      vectors++;
      if (obs0 !== 25'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0})) begin
         miscompares++;
         $display("FAIL mid_reset0: got %h expected %h", obs0, {10'd0, 10'd0, 5'b11100});
      end
      rst0 = 0;
      repeat (900) begin
         cycle();
         vectors++;
         if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL after_reset0: got %h expected %h at n=%0d", obs0, exp0(), n0);
         end
      end
      pe0 = 0;
   endtask

   task automatic test_frame();
      int vs_act = 0, bl_fall = -1, prev_y = -1;
      bit prev_bl = 1;
      int fs_n[$];
      rst1 = 1; pe1 = 0; cycle(); rst1 = 0;
      for (int c = 0; c < 5000 && n1 < 3 * FR1 + 3; c++) begin
         pe1 = $urandom_range(0, 1);
         cycle();
         vectors++;
         if (obs1 !== exp1()) begin
            miscompares++;
            $display("FAIL frame1: got %h expected %h at n=%0d", obs1, exp1(), n1);
         end
         vectors++;
         if (obs0 !== exp0()) begin
            miscompares++;
            $display("FAIL frozen0: got %h expected %h", obs0, exp0());
         end
         if (t1) begin
            if (n1 > FR1 && n1 <= 2 * FR1 && vsync1) vs_act++;
            if (fs1) begin
               fs_n.push_back(n1);
               vectors++;
               if (prev_y != VT1 - 1 || y1 !== 10'd0) begin
                  miscompares++;
                  $display("FAIL y_wrap: got %0d->%0d expected %0d->0", prev_y, y1, VT1 - 1);
               end
            end
            if (n1 > FR1 && y1 == 10'd0 && prev_bl && !blank1 && bl_fall < 0) bl_fall = x1;
            prev_bl = blank1;
            prev_y  = y1;
         end
      end
      vectors++;
      if (vs_act != S_VS * HT1) begin
         miscompares++;
         $display("FAIL vsync_width: got %0d expected %0d", vs_act, S_VS * HT1);
      end
      vectors++;
      if (bl_fall != 2) begin
         miscompares++;
         $display("FAIL blank_fall: got x=%0d expected x=2", bl_fall);
      end
      vectors++;
      if (fs_n.size() != 3 || fs_n[1] - fs_n[0] != FR1 || fs_n[2] - fs_n[1] != FR1) begin
         miscompares++;
         $display("FAIL frame_period: got %0d pulses expected 3 pulses %0d apart", fs_n.size(), FR1);
      end
      repeat ($urandom_range(1, 100)) begin
         pe1 = $urandom_range(0, 1);
         cycle();
         vectors++;
         if (obs1 !== exp1()) begin
            miscompares++;
            $display("FAIL pre_reset1: got %h expected %h at n=%0d", obs1, exp1(), n1);
         end
      end
      rst1 = 1; pe1 = 1;
      cycle();
      vectors++;
      if (obs1 !== 25'({10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0})) begin
         miscompares++;
         $display("FAIL mid_reset1: got %h expected %h", obs1, {10'd0, 10'd0, 5'b00100});
      end
      rst1 = 0; pe1 = 0;
   endtask

   task automatic test_back_to_back();
      int nf;
      bit saw_wrap = 0;
`ifdef VGA_FRAME_COUNTER_EN
      nf = 257;
`else
      nf = 3;
`endif
      rst1 = 1; pe1 = 1; cycle(); rst1 = 0;
      for (int c = 0; c < nf * FR1 + 4; c++) begin
         cycle();
         vectors++;
         if (obs1 !== exp1()) begin
            miscompares++;
            $display("FAIL b2b1: got %h expected %h at n=%0d", obs1, exp1(), n1);
         end
`ifdef VGA_FRAME_COUNTER_EN
         vectors++;
         if (fc1 !== 8'((n1 / FR1) % 256)) begin
            miscompares++;
            $display("FAIL frame_count: got %0d expected %0d", fc1, (n1 / FR1) % 256);
         end
         if (n1 == 256 * FR1 && fc1 === 8'd0) saw_wrap = 1;
`else
         if (n1 == nf * FR1 && fs1 === 1'b1) saw_wrap = 1;
`endif
      end
      pe1 = 0;
      vectors++;
      if (!saw_wrap) begin
         miscompares++;
         $display("FAIL final_wrap: got no wrap expected wrap after %0d frames", nf);
      end
   endtask

   initial begin
      rst0 = 1; rst1 = 1; pe0 = 0; pe1 = 0;
      test_reset();
      test_line();
      test_mid_reset();
      test_frame();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
